// File: rtl/mem_req_sequencer_if.sv
// Request, response and memory-side signal bundle for mem_req_sequencer.
// The master side issues requests and models the memory; the slave side is the sequencer.
interface mem_req_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [4:0]       req_addr;
  logic [7:0]       req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [4:0]       rsp_addr;
  logic [7:0]       rsp_data;
  logic             mem_rd_en;
  logic             mem_wr_en;
  logic [4:0]       mem_addr;
  logic [7:0]       mem_data_in;
  logic [7:0]       mem_data_out;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output req_valid, req_wr, req_addr, req_data, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_addr, rsp_data,
           mem_rd_en, mem_wr_en, mem_addr, mem_data_in, fifo_count
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_addr, rsp_data,
           mem_rd_en, mem_wr_en, mem_addr, mem_data_in, fifo_count
  );
endinterface

// File: rtl/mem_req_sequencer.sv
// Buffers read/write requests in a FIFO and sequences them onto a 32x8 XOR-write
// synchronous memory, returning read data over a valid/ready response channel.
module mem_req_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               rst,
  mem_req_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, RSP} state_t;

  state_t state, state_n;

  logic             fifo_wr   [DEPTH];
  logic [4:0]       fifo_addr [DEPTH];
  logic [7:0]       fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic       full, empty, push, pop;
  logic       head_wr;
  logic [4:0] head_addr;
  logic [7:0] head_data;

  logic       rd_en_q, rd_en_n;
  logic       wr_en_q, wr_en_n;
  logic [4:0] addr_q, addr_n;
  logic [7:0] din_q, din_n;
  logic       rsp_valid_q, rsp_valid_n;
  logic [4:0] rsp_addr_q, rsp_addr_n;
  logic [7:0] rsp_data_q, rsp_data_n;
  logic [4:0] rd_addr_q, rd_addr_n;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.req_valid && !full;
  assign head_wr   = fifo_wr[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Request FIFO: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]   <= bus.req_wr;
      fifo_addr[wr_ptr] <= bus.req_addr;
      fifo_data[wr_ptr] <= bus.req_data;
    end
  end

  // Next-state and next-output logic; enables drop unless an access is issued
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    rd_en_n     = 1'b0;
    wr_en_n     = 1'b0;
    addr_n      = addr_q;
    din_n       = din_q;
    rsp_valid_n = rsp_valid_q;
    rsp_addr_n  = rsp_addr_q;
    rsp_data_n  = rsp_data_q;
    rd_addr_n   = rd_addr_q;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          addr_n = head_addr;
          if (head_wr) begin
            wr_en_n = 1'b1;
            din_n   = head_data;
            state_n = WR;
          end else begin
            rd_en_n   = 1'b1;
            rd_addr_n = head_addr;
            state_n   = RD;
          end
        end
      end
      WR: begin
        if (!empty && head_wr) begin
          pop     = 1'b1;
          wr_en_n = 1'b1;
          addr_n  = head_addr;
          din_n   = head_data;
        end else begin
          state_n = IDLE;
        end
      end
      // Memory samples the read on the RD->CAP edge; data_out is valid in CAP
      RD:  state_n = CAP;
      CAP: begin
        rsp_data_n  = bus.mem_data_out;
        rsp_addr_n  = rd_addr_q;
        rsp_valid_n = 1'b1;
        state_n     = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rd_addr_q   <= '0;
    end else begin
      state       <= state_n;
      rd_en_q     <= rd_en_n;
      wr_en_q     <= wr_en_n;
      addr_q      <= addr_n;
      din_q       <= din_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_addr_q  <= rsp_addr_n;
      rsp_data_q  <= rsp_data_n;
      rd_addr_q   <= rd_addr_n;
    end
  end

  assign bus.req_ready   = !full;
  assign bus.fifo_count  = count;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = din_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_mem_req_sequencer.sv
// Scoreboard bench for mem_req_sequencer with a behavioural 32x8 XOR-write memory.
module tb_mem_req_sequencer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  mem_req_sequencer_if #(.DEPTH(DEPTH)) bus ();

  mem_req_sequencer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory: XOR on write, registered read data
  logic [7:0] tbmem [32] = '{default: 8'h00};
  logic [7:0] tb_dout = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_wr_en) tbmem[bus.mem_addr] <= tbmem[bus.mem_addr] ^ bus.mem_data_in;
    if (bus.mem_rd_en) tb_dout <= tbmem[bus.mem_addr];
  end
  assign bus.mem_data_out = tb_dout;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int overlap_cnt = 0, rd_total = 0, wr_total = 0, wr_run = 0, wr_run_max = 0;
  int wr_in_rsp = 0, unstable_cnt = 0, rsp_seen = 0, last_lat = -1, rd_rise_cyc = 0;
  int n_acc = 0;
  logic prev_rd = 1'b0, prev_rsp_v = 1'b0, prev_hs = 1'b0;
  logic [4:0] prev_raddr = '0;
  logic [7:0] prev_rdata = '0;
  logic [7:0] model [32] = '{default: 8'h00};
  rsp_t sb[$];
  bit rnd_on;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit wr, input logic [4:0] a, input logic [7:0] d,
                      input logic [7:0] exp, input bit track);
    int guard;
    bit acc;
    guard = 0;
    acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    while (!acc && guard < 300) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("push_timeout", 0, 1);
    else if (track) begin
      n_acc++;
      if (wr) model[a] = model[a] ^ d;
      else sb.push_back({a, exp});
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.fifo_count == 0 && !bus.mem_wr_en && !bus.mem_rd_en
          && !bus.rsp_valid) done = 1'b1;
    end
    check(name, int'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    fork
      begin : monitor
        rsp_t e;
        forever begin
          @(negedge clk);
          cyc++;
          if (!rst) begin
            if (bus.mem_rd_en && bus.mem_wr_en) overlap_cnt++;
            if (bus.mem_rd_en) rd_total++;
            if (bus.mem_wr_en) begin
              wr_total++;
              wr_run++;
              if (wr_run > wr_run_max) wr_run_max = wr_run;
            end else wr_run = 0;
            if (bus.mem_wr_en && bus.rsp_valid) wr_in_rsp++;
            if (bus.mem_rd_en && !prev_rd) rd_rise_cyc = cyc;
            if (bus.rsp_valid && !prev_rsp_v) last_lat = cyc - rd_rise_cyc;
            if (bus.rsp_valid && prev_rsp_v && !prev_hs &&
                (bus.rsp_data != prev_rdata || bus.rsp_addr != prev_raddr)) unstable_cnt++;
            if (bus.rsp_valid && bus.rsp_ready) begin
              rsp_seen++;
              if (sb.size() == 0) check("rsp_unexpected", int'({bus.rsp_addr, bus.rsp_data}), -1);
              else begin
                e = sb.pop_front();
                check("rsp_addr", int'(bus.rsp_addr), int'(e.addr));
                check("rsp_data", int'(bus.rsp_data), int'(e.data));
              end
            end
            prev_rd    = bus.mem_rd_en;
            prev_rsp_v = bus.rsp_valid;
            prev_hs    = bus.rsp_valid && bus.rsp_ready;
            prev_rdata = bus.rsp_data;
            prev_raddr = bus.rsp_addr;
          end else begin
            prev_rd    = 1'b0;
            prev_rsp_v = 1'b0;
            prev_hs    = 1'b0;
          end
        end
      end
      begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
      end
      begin : stimulus
        int rd0, wr0, seen0, base;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_count", int'(bus.fifo_count), 0);
        check("rst_req_ready", int'(bus.req_ready), 1);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_enables", int'({bus.mem_rd_en, bus.mem_wr_en}), 0);
        check("rst_mem_addr_data", int'({bus.mem_addr, bus.mem_data_in}), 0);
        check("rst_rsp_addr_data", int'({bus.rsp_addr, bus.rsp_data}), 0);

        // XOR merge and read latency
        push(1, 5'd3, 8'h5A, 8'h00, 1);
        push(1, 5'd3, 8'h0F, 8'h00, 1);
        push(0, 5'd3, 8'h00, 8'h55, 1);
        bus.req_valid = 1'b0;
        wait_idle("idle_xor_read", 60);
        check("read_latency", last_lat, 2);

        // Four back-to-back writes
        rd0 = rd_total;
        wr0 = wr_total;
        push(1, 5'd0, 8'h11, 8'h00, 1);
        push(1, 5'd1, 8'h22, 8'h00, 1);
        push(1, 5'd2, 8'h33, 8'h00, 1);
        push(1, 5'd3, 8'h44, 8'h00, 1);
        bus.req_valid = 1'b0;
        wait_idle("idle_wr_burst", 60);
        check("burst_wr_cycles", wr_total - wr0, 4);
        check("burst_wr_run", wr_run_max, 4);
        check("burst_no_rd", rd_total - rd0, 0);
        check("burst_count_zero", int'(bus.fifo_count), 0);
        check("hold_mem_addr", int'(bus.mem_addr), 3);
        check("hold_mem_data_in", int'(bus.mem_data_in), 8'h44);

        // Read backpressure with full FIFO behind it
        bus.rsp_ready = 1'b0;
        push(0, 5'd3, 8'h00, 8'h11, 1);
        push(1, 5'd8, 8'h01, 8'h00, 1);
        push(1, 5'd9, 8'h02, 8'h00, 1);
        push(1, 5'd10, 8'h03, 8'h00, 1);
        push(1, 5'd11, 8'h04, 8'h00, 1);
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_rsp_valid", int'(bus.rsp_valid), 1);
        check("stall_rsp_data", int'(bus.rsp_data), 8'h11);
        check("stall_count_full", int'(bus.fifo_count), DEPTH);
        check("stall_req_ready", int'(bus.req_ready), 0);
        bus.rsp_ready = 1'b1;
        wait_idle("idle_stall_drain", 60);

        // Six requests against a stalled sequencer, valid held high
        bus.rsp_ready = 1'b0;
        push(0, 5'd5, 8'h00, 8'h00, 1);
        base = n_acc;
        fork
          begin
            push(1, 5'd12, 8'h01, 8'h00, 1);
            push(1, 5'd12, 8'h02, 8'h00, 1);
            push(0, 5'd12, 8'h00, 8'h03, 1);
            push(1, 5'd13, 8'h10, 8'h00, 1);
            push(0, 5'd13, 8'h00, 8'h10, 1);
            push(0, 5'd12, 8'h00, 8'h03, 1);
            bus.req_valid = 1'b0;
          end
          begin
            repeat (8) @(posedge clk);
            #1;
            check("six_accepted_while_stalled", n_acc - base, 4);
            check("six_count_full", int'(bus.fifo_count), DEPTH);
            check("six_req_ready_low", int'(bus.req_ready), 0);
            bus.rsp_ready = 1'b1;
          end
        join
        wait_idle("idle_six", 100);
        check("six_all_accepted", n_acc - base, 6);

        // Reset while capturing a read with two writes queued
        push(0, 5'd0, 8'h00, 8'h00, 0);
        push(1, 5'd1, 8'hFF, 8'h00, 0);
        push(1, 5'd2, 8'hFF, 8'h00, 0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen0 = rsp_seen;
        check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
        check("midrst_count", int'(bus.fifo_count), 0);
        check("midrst_enables", int'({bus.mem_rd_en, bus.mem_wr_en}), 0);
        check("midrst_req_ready", int'(bus.req_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_response", rsp_seen - seen0, 0);

        // Random mix against the XOR memory model
        rnd_on = 1'b1;
        fork
          begin
            logic [4:0] a;
            logic [7:0] d;
            for (int i = 0; i < 200; i++) begin
              a = 5'($urandom_range(0, 7));
              d = 8'($urandom_range(0, 255));
              if ($urandom_range(0, 1) == 1) push(1, a, d, 8'h00, 1);
              else push(0, a, 8'h00, model[a], 1);
              if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                @(posedge clk);
                #1;
              end
            end
            bus.req_valid = 1'b0;
            rnd_on = 1'b0;
          end
          begin
            while (rnd_on) begin
              @(posedge clk);
              #1 bus.rsp_ready = ($urandom_range(0, 2) != 0);
            end
          end
        join
        bus.rsp_ready = 1'b1;
        wait_idle("idle_random", 400);

        check("rd_wr_exclusive", overlap_cnt, 0);
        check("no_write_during_rsp", wr_in_rsp, 0);
        check("rsp_held_stable", unstable_cnt, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
      end
    join
  end
endmodule
